fp_serial_frame_io: RTL and testbench



---
 rtl/fp_serial_frame_io_pkg.sv | 21 ++
 rtl/fp_serial_frame_io_if.sv | 26 ++
 rtl/fp_serial_frame_io_tx.sv | 59 +++++
 rtl/fp_serial_frame_io.sv | 105 ++++++++++
 tb/tb_fp_serial_frame_io.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fp_serial_frame_io_pkg.sv
// Shared types and constants for the FP adder serial front/back end.
// The FP_SERIAL_PARITY_EN build adds a trailing even-parity bit after the result.
package fp_serial_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        HANDOFF  = 3'd2,
        WAIT_RES = 3'd3,
        SHIFT    = 3'd4,
        PARITY   = 3'd5
    } state_t;

    localparam int WIDTH_DEF  = 32;
    localparam int FRAME_BITS = 2 * WIDTH_DEF;

    function automatic int frame_bits(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/fp_serial_frame_io_if.sv
// Operand/result bus between the serial line, the frame I/O block and the adder core.
interface fp_serial_frame_io_if #(
    parameter int WIDTH = 32
);
    logic             serial_in;
    logic             en_in;
    logic [WIDTH-1:0] op_a_out;
    logic [WIDTH-1:0] op_b_out;
    logic             op_valid_out;
    logic             op_ready_in;
    logic [WIDTH-1:0] result_in;
    logic             result_valid_in;
    logic             serial_out;
    logic             serial_out_valid;
    logic             busy_out;

    modport slave (
        input  serial_in, en_in, op_ready_in, result_in, result_valid_in,
        output op_a_out, op_b_out, op_valid_out, serial_out, serial_out_valid, busy_out
    );

    modport master (
        output serial_in, en_in, op_ready_in, result_in, result_valid_in,
        input  op_a_out, op_b_out, op_valid_out, serial_out, serial_out_valid, busy_out
    );
endinterface

// File: rtl/fp_serial_frame_io_tx.sv
// LSB-first PISO for the adder result; FP_SERIAL_PARITY_EN appends one even-parity bit.
module fp_serial_tx #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 7
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             serial_out,
    output logic             serial_out_valid,
    output logic             done
);
    logic [WIDTH-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic             active;

    // done marks the cycle carrying the last result bit
    assign done = active && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (done) active <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (load)        sr <= data;
        else if (active) sr <= sr >> 1;
    end

`ifdef FP_SERIAL_PARITY_EN
    logic par_bit;
    logic par_phase;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) par_phase <= 1'b0;
        else        par_phase <= done;
    end

    always_ff @(posedge clk_in) begin
        if (load) par_bit <= ^data;
    end

    assign serial_out       = active ? sr[0] : (par_phase & par_bit);
    assign serial_out_valid = active | par_phase;
`else
    assign serial_out       = active & sr[0];
    assign serial_out_valid = active;
`endif

endmodule

// File: rtl/fp_serial_frame_io.sv
// Deserialises an A/B operand frame, hands it to the adder, serialises the sum back.
// Build with FP_SERIAL_PARITY_EN to add the PARITY state and trailing parity bit.
module fp_serial_frame_io
    import fp_serial_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 7
) (
    input logic                clk_in,
    input logic                rst_in,
    fp_serial_frame_io_if.slave bus
);
    localparam int FRAME_LEN = frame_bits(WIDTH);
    localparam int IDX_W     = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] b_off;
    logic [WIDTH-1:0] op_a, op_b;
    logic             op_valid;
    logic             last_bit;
    logic             tx_load, tx_done;
    logic             tx_so, tx_sov;

    assign b_off    = cnt - CNT_W'(WIDTH);
    assign last_bit = (cnt == CNT_W'(FRAME_LEN - 1));
    assign tx_load  = (state == WAIT_RES) && bus.result_valid_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.en_in) state_nxt = LOAD;
            LOAD: begin
                if (!bus.en_in)    state_nxt = IDLE;
                else if (last_bit) state_nxt = HANDOFF;
            end
            HANDOFF:  if (bus.op_ready_in) state_nxt = WAIT_RES;
            WAIT_RES: if (bus.result_valid_in) state_nxt = SHIFT;
`ifdef FP_SERIAL_PARITY_EN
            SHIFT:    if (tx_done) state_nxt = PARITY;
            PARITY:   state_nxt = IDLE;
`else
            SHIFT:    if (tx_done) state_nxt = IDLE;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    // Partial bits survive an aborted frame; only the counter restarts.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            op_a     <= '0;
            op_b     <= '0;
            op_valid <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en_in) begin
                        op_a[0] <= bus.serial_in;
                        cnt     <= CNT_W'(1);
                    end
                end
                LOAD: begin
                    if (bus.en_in) begin
                        if (cnt < CNT_W'(WIDTH)) op_a[cnt[IDX_W-1:0]]   <= bus.serial_in;
                        else                     op_b[b_off[IDX_W-1:0]] <= bus.serial_in;
                        cnt <= cnt + 1'b1;
                        if (last_bit) op_valid <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                HANDOFF: if (bus.op_ready_in) op_valid <= 1'b0;
                default: if (state_nxt == IDLE) cnt <= '0;
            endcase
        end
    end

    fp_serial_tx #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_tx (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .load             (tx_load),
        .data             (bus.result_in),
        .serial_out       (tx_so),
        .serial_out_valid (tx_sov),
        .done             (tx_done)
    );

    assign bus.op_a_out         = op_a;
    assign bus.op_b_out         = op_b;
    assign bus.op_valid_out     = op_valid;
    assign bus.serial_out       = tx_so;
    assign bus.serial_out_valid = tx_sov;
    assign bus.busy_out         = (state != IDLE) && (state != LOAD);

endmodule

// File: tb/tb_fp_serial_frame_io.sv
// Scoreboard bench for fp_serial_frame_io: operand frames and serial result bits.
module tb_fp_serial_frame_io;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [63:0] op_q[$];
    logic        bit_q[$];

    fp_serial_frame_io_if #(.WIDTH(32)) bus ();

    fp_serial_frame_io #(.WIDTH(32), .CNT_W(7)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (bus.serial_out_valid === 1'b1) begin
            if (bit_q.size() == 0) check_val("tx_extra_bit", 32'(bus.serial_out), 32'hx);
            else                   check_val("tx_bit", 32'(bus.serial_out), 32'(bit_q.pop_front()));
        end
    end

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input int nbits);
        logic [63:0] f;
        f = {b, a};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.en_in     = 1'b1;
            bus.serial_in = f[i];
        end
        @(negedge clk);
        bus.en_in     = 1'b0;
        bus.serial_in = 1'b0;
        if (nbits == 64) op_q.push_back({a, b});
    endtask

    task automatic check_ops(input string tag);
        logic [63:0] e;
        if (op_q.size() == 0) begin
            check_val({tag, "_no_expected"}, 32'd0, 32'd1);
        end else begin
            e = op_q.pop_front();
            check_val({tag, "_op_a"}, bus.op_a_out, e[63:32]);
            check_val({tag, "_op_b"}, bus.op_b_out, e[31:0]);
        end
    endtask

    task automatic push_result(input logic [31:0] r);
        for (int i = 0; i < 32; i++) bit_q.push_back(r[i]);
`ifdef FP_SERIAL_PARITY_EN
        bit_q.push_back(^r);
`endif
    endtask

    task automatic handoff_ready;
        @(negedge clk);
        bus.op_ready_in = 1'b1;
        @(negedge clk);
        bus.op_ready_in = 1'b0;
        check_val("ready_clears_valid", 32'(bus.op_valid_out), 32'd0);
        check_val("wait_res_busy", 32'(bus.busy_out), 32'd1);
    endtask

    task automatic send_result(input logic [31:0] r, input bit toggle_en);
        int budget;
        @(negedge clk);
        bus.result_in       = r;
        bus.result_valid_in = 1'b1;
        push_result(r);
        @(negedge clk);
        bus.result_valid_in = 1'b0;
        budget = 0;
        while (bit_q.size() != 0 && budget < 60) begin
            if (toggle_en && budget < 20) begin
                bus.en_in     = 1'($urandom);
                bus.serial_in = 1'($urandom);
            end else begin
                bus.en_in = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        bus.en_in = 1'b0;
        check_val("tx_all_bits_seen", 32'(bit_q.size()), 32'd0);
        @(negedge clk);
        check_val("tx_done_valid_low", 32'(bus.serial_out_valid), 32'd0);
        check_val("tx_done_idle", 32'(bus.busy_out), 32'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        bus.en_in           = 1'b0;
        bus.serial_in       = 1'b0;
        bus.op_ready_in     = 1'b0;
        bus.result_in       = '0;
        bus.result_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_op_a", bus.op_a_out, 32'd0);
        check_val("rst_op_b", bus.op_b_out, 32'd0);
        check_val("rst_op_valid", 32'(bus.op_valid_out), 32'd0);
        check_val("rst_sov", 32'(bus.serial_out_valid), 32'd0);
        check_val("rst_so", 32'(bus.serial_out), 32'd0);
        check_val("rst_busy", 32'(bus.busy_out), 32'd0);
        rst = 1'b0;

        send_frame(32'h3F800000, 32'h40000000, 64);
        check_val("f1_op_valid", 32'(bus.op_valid_out), 32'd1);
        check_val("f1_busy", 32'(bus.busy_out), 32'd1);
        check_ops("f1");

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.result_in       = 32'h12345678;
            bus.result_valid_in = (i == 2);
        end
        @(negedge clk);
        bus.result_valid_in = 1'b0;
        check_val("hold_op_valid", 32'(bus.op_valid_out), 32'd1);
        check_val("hold_op_a", bus.op_a_out, 32'h3F800000);
        check_val("hold_op_b", bus.op_b_out, 32'h40000000);
        check_val("hold_busy", 32'(bus.busy_out), 32'd1);
        handoff_ready();

        send_result(32'h40400000, 1'b1);
        check_val("shift_en_op_a", bus.op_a_out, 32'h3F800000);
        check_val("shift_en_op_b", bus.op_b_out, 32'h40000000);

        send_frame(32'hFFFFFFFF, 32'hFFFFFFFF, 10);
        check_val("abort_no_valid", 32'(bus.op_valid_out), 32'd0);
        check_val("abort_idle", 32'(bus.busy_out), 32'd0);
        send_frame(32'h00000001, 32'h80000000, 64);
        check_val("f2_op_valid", 32'(bus.op_valid_out), 32'd1);
        check_ops("f2");
        handoff_ready();
        send_result(32'hC0A00001, 1'b0);

        send_frame(32'hA5A5A5A5, 32'h5A5A5A5A, 64);
        check_ops("f3");
        handoff_ready();
        @(negedge clk);
        bus.result_in       = 32'hDEADBEEF;
        bus.result_valid_in = 1'b1;
        push_result(32'hDEADBEEF);
        @(negedge clk);
        bus.result_valid_in = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_sov", 32'(bus.serial_out_valid), 32'd0);
        check_val("mid_rst_so", 32'(bus.serial_out), 32'd0);
        check_val("mid_rst_op_a", bus.op_a_out, 32'd0);
        check_val("mid_rst_op_valid", 32'(bus.op_valid_out), 32'd0);
        check_val("mid_rst_busy", 32'(bus.busy_out), 32'd0);
        check_val("mid_rst_bits_left", 32'(bit_q.size()), 32'd20
`ifdef FP_SERIAL_PARITY_EN
            + 32'd1
`endif
        );
        bit_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("post_rst_sov", 32'(bus.serial_out_valid), 32'd0);

        send_frame(32'h12345678, 32'h9ABCDEF0, 64);
        check_val("f4_op_valid", 32'(bus.op_valid_out), 32'd1);
        check_ops("f4");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
